serial_adder: RTL and testbench

//   Bit-serial adder built around a single full-adder cell. It accepts two

---
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder that sequences one full-adder cell over
// WIDTH clocks (LSB first), with valid/ready handshakes on both sides.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    count;

  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  // The single full-adder cell fed from the bottom of the operand shift regs
  assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_co    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_bit = (count == CW'(WIDTH - 1));

  // Handshake and status outputs are pure decodes of the state, so an
  // asynchronous reset drops out_valid and busy without waiting for an edge.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: accept in IDLE, run WIDTH bit-steps, hold in DONE until taken
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per RUN cycle, and latch
  // the visible result only on the final bit so sum/cout stay frozen otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            count <= '0;
          end
        end
        RUN: begin
          sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_co;
          if (last_bit) begin
            sum_q  <= {fa_s, sum_sr[WIDTH-1:1]};
            cout_q <= fa_co;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomised checks of serial_adder at WIDTH=8.
module tb_serial_adder;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  int compareCount;
  int mismatchCount;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE: accept, scramble don't-care inputs during RUN,
  // wait for the result, stall in DONE for 'stall' cycles, then take it.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic ci, input logic [8:0] expected,
                               input int stall);
    int cyc;
    a         = av;
    b         = bv;
    cin       = ci;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    nextCycle();
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    cin      = 1'($urandom);
    cyc      = 0;
    while (!out_valid && cyc < 40) begin
      checkOutput("in_ready low while busy", in_ready, 0);
      out_ready = 1'($urandom);
      nextCycle();
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput("latency", cyc, 8);
    checkOutput("result", {cout, sum}, expected);
    checkOutput("in_ready in DONE", in_ready, 0);
    checkOutput("busy in DONE", busy, 1);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
      nextCycle();
      checkOutput("stall out_valid", out_valid, 1);
      checkOutput("stall result", {cout, sum}, expected);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nextCycle();
    out_ready = 1'b0;
    checkOutput("released out_valid", out_valid, 0);
    checkOutput("released in_ready", in_ready, 1);
    checkOutput("result held in IDLE", {cout, sum}, expected);
  endtask

  logic [7:0] vecA [3];
  logic [7:0] vecB [3];
  logic       vecC [3];
  int         acceptCycle [3];

  initial begin
    int cyc;
    int acc;
    int res;
    logic [8:0] model;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    compareCount  = 0;
    mismatchCount = 0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a         = 8'h55;
    b         = 8'h66;
    cin       = 1'b1;
    nextCycle();
    nextCycle();

    // Reset state, with in_valid high being ignored during reset
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset sum", sum, 0);
    checkOutput("reset cout", cout, 0);
    in_valid = 1'b0;
    reset    = 1'b0;
    nextCycle();
    checkOutput("idle after reset", busy, 0);

    // Directed vectors
    applyStimulus(8'h00, 8'h00, 1'b0, 9'h000, 0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 9'h100, 0);
    applyStimulus(8'hA5, 8'h5A, 1'b1, 9'h100, 1);
    applyStimulus(8'h12, 8'h34, 1'b0, 9'h046, 5);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 9'h1FF, 0);
    applyStimulus(8'h80, 8'h80, 1'b0, 9'h100, 2);
    applyStimulus(8'h00, 8'h00, 1'b1, 9'h001, 0);

    // Reset during the 4th RUN cycle aborts at once
    a        = 8'h7F;
    b        = 8'h80;
    cin      = 1'b1;
    in_valid = 1'b1;
    nextCycle();
    in_valid = 1'b0;
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("busy before abort", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort in_ready", in_ready, 1);
    nextCycle();
    reset = 1'b0;
    checkOutput("abort sum cleared", {cout, sum}, 0);
    applyStimulus(8'h7F, 8'h80, 1'b1, 9'h100, 0);

    // Reset while holding a result in DONE drops out_valid without an edge
    a        = 8'h12;
    b        = 8'h34;
    cin      = 1'b0;
    in_valid = 1'b1;
    nextCycle();
    in_valid = 1'b0;
    cyc      = 0;
    while (!out_valid && cyc < 40) begin
      nextCycle();
      cyc++;
    end
    checkOutput("pre-abort DONE", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("DONE abort out_valid", out_valid, 0);
    checkOutput("DONE abort busy", busy, 0);
    nextCycle();
    reset = 1'b0;
    nextCycle();

    // Back-to-back with in_valid and out_ready held high
    vecA[0] = 8'h3C; vecB[0] = 8'hC4; vecC[0] = 1'b0;
    vecA[1] = 8'h99; vecB[1] = 8'h77; vecC[1] = 1'b1;
    vecA[2] = 8'h01; vecB[2] = 8'h02; vecC[2] = 1'b1;
    a         = vecA[0];
    b         = vecB[0];
    cin       = vecC[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    acc = 0;
    res = 0;
    while (res < 3 && cyc < 100) begin
      if (out_valid) begin
        model = vecA[res] + vecB[res] + 9'(vecC[res]);
        checkOutput("b2b result", {cout, sum}, model);
        res++;
      end
      if (in_ready && acc < 3) begin
        acceptCycle[acc] = cyc;
        acc++;
      end
      nextCycle();
      if (acc < 3) begin
        a   = vecA[acc];
        b   = vecB[acc];
        cin = vecC[acc];
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("b2b results seen", res, 3);
    checkOutput("b2b accepts seen", acc, 3);
    if (acc == 3) begin
      checkOutput("b2b spacing 0-1", acceptCycle[1] - acceptCycle[0], 10);
      checkOutput("b2b spacing 1-2", acceptCycle[2] - acceptCycle[1], 10);
    end
    nextCycle();
    checkOutput("b2b idle", busy, 0);

    // Random sweep with random stalls in DONE
    for (int n = 0; n < 1000; n++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      rc    = 1'($urandom);
      model = ra + rb + 9'(rc);
      applyStimulus(ra, rb, rc, model, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
